hamming_secded_pipe: RTL and testbench

Parametrised, pipelined Hamming SECDED (single-error-correct, double-error-detect) decoder with valid/ready flow control and saturating error counters. Generalises the fixed 16-bit combinational SEC decoder to any data width. Adds an overall-parity bit for double-error detection, a correction-enable mode and error statistics. Sits between memory read data and the consumer, one codeword per cycle.

---
 rtl/hamming_pkg.sv | 51 +++++
 rtl/hamming_syndrome.sv | 25 ++
 rtl/hamming_secded_pipe.sv | 179 +++++++++++++++++
 tb/tb_hamming_secded_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and helpers for the Hamming SECDED decoder family.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package hamming_pkg;

    // Decoded beat classification; the value 2'b11 is never produced.
    typedef enum logic [1:0] {
        CLEAN  = 2'b00,
        SINGLE = 2'b01,
        UNCORR = 2'b10
    } hstat_e;

    // Smallest P with 2^P >= data_w + P + 1.
    function automatic int hamming_p(input int data_w);
        int p;
        p = 1;
        while ((1 << p) < data_w + p + 1) begin
            p = p + 1;
        end
        return p;
    endfunction

    // Codeword position of data bit idx: data bits fill the
    // non-power-of-two positions in ascending order, starting at 3.
    function automatic int data_pos(input int idx);
        int pos;
        int cnt;
        pos = 2;
        cnt = -1;
        while (cnt < idx) begin
            pos = pos + 1;
            if ((pos & (pos - 1)) != 0) begin
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

    // Data bits that feed syndrome bit k (those whose position has bit k set).
    function automatic logic [63:0] syn_mask(input int k, input int data_w);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < data_w; i++) begin
            if (((data_pos(i) >> k) & 1) == 1) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Hamming syndrome and overall-parity mismatch of a received codeword.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int DATA_W = 16,
    localparam int P = hamming_p(DATA_W)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [P:0]        check,
    output logic [P-1:0]      syndrome,
    output logic              om
);

    // Each syndrome bit re-derives one Hamming check and compares it with the received one.
    for (genvar k = 0; k < P; k++) begin : g_syn
        localparam logic [63:0] MASK = syn_mask(k, DATA_W);
        assign syndrome[k] = check[k] ^ (^(data & MASK[DATA_W-1:0]));
    end

    // Even parity across every received bit, overall-parity bit included.
    assign om = (^data) ^ (^check);

endmodule

// File: rtl/hamming_secded_pipe.sv
// Two-stage pipelined Hamming SECDED decoder with saturating error counters.
// Latency: 2 cycles from input accept to out_valid; 1 beat/cycle throughput.
// Backpressure: valid/ready; in_ready follows out_ready combinationally, holds 2 beats when stalled.
module hamming_secded_pipe
    import hamming_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16,
    localparam int P = hamming_p(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [P:0]        in_check,
    input  logic              correct_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_status,
    output logic [P-1:0]      out_syndrome,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    // Highest valid codeword position; syndromes above it cannot be a single error.
    localparam int N = DATA_W + P;

    logic [P-1:0]      syn_w;
    logic              om_w;

    logic              s1_vld_q, s1_vld_d;
    logic [P-1:0]      s1_syn_q, s1_syn_d;
    logic              s1_om_q, s1_om_d;
    logic [DATA_W-1:0] s1_dat_q, s1_dat_d;
    logic              s1_cen_q, s1_cen_d;

    logic              s2_vld_q, s2_vld_d;
    logic [DATA_W-1:0] s2_dat_q, s2_dat_d;
    hstat_e            s2_stat_q, s2_stat_d;
    logic [P-1:0]      s2_syn_q, s2_syn_d;

    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

    logic              s1_load;
    logic              s2_load;
    logic              xfer;
    logic [DATA_W-1:0] fix_mask;
    hstat_e            dec_stat;
    logic [DATA_W-1:0] dec_dat;

    hamming_syndrome #(
        .DATA_W (DATA_W)
    ) u_syn (
        .data     (in_data),
        .check    (in_check),
        .syndrome (syn_w),
        .om       (om_w)
    );

    // Stage 2 frees up whenever it is empty or its beat leaves; stage 1 then follows.
    assign s2_load  = !s2_vld_q | out_ready;
    assign s1_load  = !s1_vld_q | s2_load;
    assign in_ready = s1_load;
    assign xfer     = s2_vld_q & out_ready;

    // One-hot flip mask: the data bit whose codeword position equals the syndrome.
    for (genvar i = 0; i < DATA_W; i++) begin : g_fix
        localparam int POS = data_pos(i);
        assign fix_mask[i] = (s1_syn_q == P'(POS));
    end

    // Stage 1 captures syndrome, parity mismatch, raw data and the correction mode.
    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_syn_d = s1_syn_q;
        s1_om_d  = s1_om_q;
        s1_dat_d = s1_dat_q;
        s1_cen_d = s1_cen_q;
        if (s1_load) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_syn_d = syn_w;
                s1_om_d  = om_w;
                s1_dat_d = in_data;
                s1_cen_d = correct_en;
            end
        end
    end

    // Classify the stage-1 beat and apply the single-bit correction when enabled.
    always_comb begin
        dec_stat = CLEAN;
        if (s1_syn_q == '0) begin
            dec_stat = s1_om_q ? SINGLE : CLEAN;
        end else if (s1_om_q && (s1_syn_q <= P'(N))) begin
            dec_stat = SINGLE;
        end else begin
            dec_stat = UNCORR;
        end
        dec_dat = s1_dat_q;
        if ((dec_stat == SINGLE) && s1_cen_q) begin
            dec_dat = s1_dat_q ^ fix_mask;
        end
    end

    // Stage 2 only takes new payload from a valid stage-1 beat so outputs never churn on bubbles.
    always_comb begin
        s2_vld_d  = s2_vld_q;
        s2_dat_d  = s2_dat_q;
        s2_stat_d = s2_stat_q;
        s2_syn_d  = s2_syn_q;
        if (s2_load) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_dat_d  = dec_dat;
                s2_stat_d = dec_stat;
                s2_syn_d  = s1_syn_q;
            end
        end
    end

    // Counters advance on delivered beats, saturate at all-ones, and clear wins over increment.
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (xfer) begin
            if ((s2_stat_q == SINGLE) && (corr_cnt_q != '1)) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end
            if ((s2_stat_q == UNCORR) && (uncorr_cnt_q != '1)) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset drops in-flight beats and counter contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q     <= 1'b0;
            s1_syn_q     <= '0;
            s1_om_q      <= 1'b0;
            s1_dat_q     <= '0;
            s1_cen_q     <= 1'b0;
            s2_vld_q     <= 1'b0;
            s2_dat_q     <= '0;
            s2_stat_q    <= CLEAN;
            s2_syn_q     <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_vld_q     <= s1_vld_d;
            s1_syn_q     <= s1_syn_d;
            s1_om_q      <= s1_om_d;
            s1_dat_q     <= s1_dat_d;
            s1_cen_q     <= s1_cen_d;
            s2_vld_q     <= s2_vld_d;
            s2_dat_q     <= s2_dat_d;
            s2_stat_q    <= s2_stat_d;
            s2_syn_q     <= s2_syn_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid    = s2_vld_q;
    assign out_data     = s2_dat_q;
    assign out_status   = s2_stat_q;
    assign out_syndrome = s2_syn_q;
    assign corr_cnt     = corr_cnt_q;
    assign uncorr_cnt   = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Directed bench for hamming_secded_pipe (DATA_W=16, CNT_W=2).
// Clean codeword for 16'hA5A5: Hamming bits 5'b00111, overall parity 1 -> in_check 6'h27.
// Data index -> position: 3,5,6,7,9,10,11,12,13,14,15,17,18,19,20,21.
module tb_hamming_secded_pipe;

    localparam int DW = 16;
    localparam int CW = 2;
    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [PW:0]   in_check;
    logic          correct_en;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_status;
    logic [PW-1:0] out_syndrome;
    logic          cnt_clr;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] uncorr_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] d;
        logic [5:0]  c;
        logic        cen;
        logic [15:0] ed;
        logic [1:0]  es;
        logic [4:0]  esyn;
    } vec_t;

    vec_t vt [11];

    hamming_secded_pipe #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_check     (in_check),
        .correct_en   (correct_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_status   (out_status),
        .out_syndrome (out_syndrome),
        .cnt_clr      (cnt_clr),
        .corr_cnt     (corr_cnt),
        .uncorr_cnt   (uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [5:0] c, input logic cen);
        in_valid   = v;
        in_data    = d;
        in_check   = c;
        correct_en = cen;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bd  [3];
        logic [5:0]  bc  [3];
        logic        bcen[3];
        logic [15:0] bo  [3];
        logic [15:0] got_d [8];
        int acc;
        int got;

        //            data      check  cen   exp data  st     syn
        vt[0]  = '{16'hA5A5, 6'h27, 1'b1, 16'hA5A5, 2'd0, 5'd0};   // clean
        vt[1]  = '{16'hA5A4, 6'h27, 1'b1, 16'hA5A5, 2'd1, 5'd3};   // pos 3 corrected
        vt[2]  = '{16'hA5A4, 6'h27, 1'b0, 16'hA5A4, 2'd1, 5'd3};   // pos 3 detect-only
        vt[3]  = '{16'hA5A5, 6'h23, 1'b1, 16'hA5A5, 2'd1, 5'd4};   // check[2] flipped
        vt[4]  = '{16'hA5A5, 6'h07, 1'b1, 16'hA5A5, 2'd1, 5'd0};   // overall bit flipped
        vt[5]  = '{16'hA5A6, 6'h27, 1'b1, 16'hA5A6, 2'd2, 5'd6};   // pos 3 and 5
        vt[6]  = '{16'h25A5, 6'h27, 1'b1, 16'hA5A5, 2'd1, 5'd21};  // last position
        vt[7]  = '{16'h25A5, 6'h27, 1'b0, 16'h25A5, 2'd1, 5'd21};  // last position, detect-only
        vt[8]  = '{16'hADA6, 6'h27, 1'b1, 16'hADA6, 2'd2, 5'd23};  // syndrome beyond codeword
        vt[9]  = '{16'h0000, 6'h00, 1'b1, 16'h0000, 2'd0, 5'd0};   // all-zero clean
        vt[10] = '{16'h0000, 6'h01, 1'b1, 16'h0000, 2'd1, 5'd1};   // check[0] flipped

        rst = 1'b1;
        drive(1'b0, 16'h0, 6'h0, 1'b0);
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_status", 32'(out_status), 32'd0);
        check("rst_out_syndrome", 32'(out_syndrome), 32'd0);
        check("rst_corr_cnt", 32'(corr_cnt), 32'd0);
        check("rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Table-driven single beats with counter clear ahead of each
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            cnt_clr = 1'b1;
            drive(1'b1, vt[i].d, vt[i].c, vt[i].cen);
            @(negedge clk);
            cnt_clr = 1'b0;
            drive(1'b0, 16'h0, 6'h0, 1'b0);
            check($sformatf("v%0d_lat1_valid", i), 32'(out_valid), 32'd0);
            check($sformatf("v%0d_clr_corr", i), 32'(corr_cnt), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_lat2_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_data", i), 32'(out_data), 32'(vt[i].ed));
            check($sformatf("v%0d_status", i), 32'(out_status), 32'(vt[i].es));
            check($sformatf("v%0d_syndrome", i), 32'(out_syndrome), 32'(vt[i].esyn));
            @(negedge clk);
            check($sformatf("v%0d_corr_cnt", i), 32'(corr_cnt), (vt[i].es == 2'd1) ? 32'd1 : 32'd0);
            check($sformatf("v%0d_uncorr_cnt", i), 32'(uncorr_cnt), (vt[i].es == 2'd2) ? 32'd1 : 32'd0);
            check($sformatf("v%0d_drained", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: 3 beats offered with out_ready low, only 2 fit
        bd[0] = 16'hA5A5; bc[0] = 6'h27; bcen[0] = 1'b1; bo[0] = 16'hA5A5;
        bd[1] = 16'h0000; bc[1] = 6'h00; bcen[1] = 1'b1; bo[1] = 16'h0000;
        bd[2] = 16'hA5A4; bc[2] = 6'h27; bcen[2] = 1'b0; bo[2] = 16'hA5A4;
        acc = 0;
        got = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (acc < 3) drive(1'b1, bd[acc], bc[acc], bcen[acc]);
            else         drive(1'b0, 16'h0, 6'h0, 1'b0);
            #1;
            if (in_valid && in_ready) acc++;
        end
        check("bp_accepted", 32'(acc), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head_stable", 32'(out_data), 32'hA5A5);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (acc < 3) drive(1'b1, bd[acc], bc[acc], bcen[acc]);
            else         drive(1'b0, 16'h0, 6'h0, 1'b0);
            #1;
            if (out_valid) begin
                if (got < 8) got_d[got] = out_data;
                got++;
            end
            if (in_valid && in_ready) acc++;
        end
        drive(1'b0, 16'h0, 6'h0, 1'b0);
        check("bp_out_count", 32'(got), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_order%0d", k), 32'(got_d[k]), 32'(bo[k]));
        end

        // Saturation: 5 single-error beats into a 2-bit counter
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 16'hA5A4, 6'h27, 1'b1);
            @(negedge clk);
        end
        drive(1'b0, 16'h0, 6'h0, 1'b0);
        repeat (4) @(negedge clk);
        check("sat_corr_cnt", 32'(corr_cnt), 32'd3);
        check("sat_uncorr_cnt", 32'(uncorr_cnt), 32'd0);

        // Clear coincident with an increment
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check("clr_idle", 32'(corr_cnt), 32'd0);
        drive(1'b1, 16'hA5A4, 6'h27, 1'b1);
        @(negedge clk);
        drive(1'b0, 16'h0, 6'h0, 1'b0);
        @(negedge clk);
        check("clr_beat_valid", 32'(out_valid), 32'd1);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check("clr_wins", 32'(corr_cnt), 32'd0);
        drive(1'b1, 16'hA5A4, 6'h27, 1'b1);
        @(negedge clk);
        drive(1'b0, 16'h0, 6'h0, 1'b0);
        repeat (2) @(negedge clk);
        check("clr_then_inc", 32'(corr_cnt), 32'd1);

        // Reset with 2 beats in flight
        out_ready = 1'b0;
        drive(1'b1, 16'hA5A5, 6'h27, 1'b1);
        @(negedge clk);
        drive(1'b1, 16'h0000, 6'h00, 1'b1);
        @(negedge clk);
        drive(1'b0, 16'h0, 6'h0, 1'b0);
        check("mid_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_corr", 32'(corr_cnt), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        check("mid_rel_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        drive(1'b1, 16'hA5A6, 6'h27, 1'b1);
        @(negedge clk);
        drive(1'b0, 16'h0, 6'h0, 1'b0);
        check("post_rst_lat1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("post_rst_lat2", 32'(out_valid), 32'd1);
        check("post_rst_data", 32'(out_data), 32'hA5A6);
        check("post_rst_status", 32'(out_status), 32'd2);
        @(negedge clk);
        check("post_rst_uncorr", 32'(uncorr_cnt), 32'd1);
        check("post_rst_corr", 32'(corr_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
